// File: rtl/cond_pkg.sv
// cond_pkg: shared definitions for the conditional-execution unit.
//   - ARM-style condition codes (COND_EQ .. COND_NV)
//   - NZCV bit positions within a flags word
//   - flags_t (4-bit {N,Z,C,V}) and exmem_t (EX/MEM strobe bundle)
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  // Registered EX/MEM strobes
  typedef struct packed {
    logic valid;
    logic pc_src;
    logic reg_write;
    logic mem_write;
    logic branch_take;
    logic cond_ex;
  } exmem_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition evaluation.
//   cond      in  4  condition field
//   flags     in  4  {N,Z,C,V}
//   nv_always in  1  result for cond 4'b1111
//   cond_ex   out 1  condition passes
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  input  logic       nv_always,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = ~z & c;
      COND_LS: cond_ex = z | ~c;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = nv_always;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: execute-stage conditional-execution unit.
// Keeps NZCV flags plus a saved shadow per hardware context, evaluates the
// instruction condition against the selected context and registers the gated
// strobes into EX/MEM. Counts annulled (condition-failed) instructions.
//   clk, reset (async, active-high)
//   in_valid/stall/flush         pipeline control
//   ctx, cond                    context select, condition field
//   pcs/reg_w/mem_w/branch/no_write  decoder strobes
//   flag_w, alu_flag             flag update enables {NZ,CV} and ALU flags
//   flag_save/flag_restore       shadow copy controls
//   cnt_clr                      clear annul counter
//   out_valid..cond_ex_q         registered EX/MEM results
//   flags_o                      flags[ctx], combinational
//   annul_cnt                    saturating annul count
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter  int NCTX       = 2,
  parameter  int GATE_FLAGS = 1,
  parameter  int NV_ALWAYS  = 0,
  parameter  int CNT_W      = 16,
  localparam int CTXW       = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [CTXW-1:0]  ctx,
  input  logic [3:0]       cond,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             branch,
  input  logic             no_write,
  input  logic [1:0]       flag_w,
  input  logic [3:0]       alu_flag,
  input  logic             flag_save,
  input  logic             flag_restore,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             branch_take,
  output logic             cond_ex_q,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] annul_cnt
);

  flags_t           flags_q [NCTX];
  flags_t           flags_d [NCTX];
  flags_t           saved_q [NCTX];
  flags_t           saved_d [NCTX];
  exmem_t           out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   ctx_ok, accept, upd, eval_ex, cond_ex;
  flags_t cur_flags, new_flags;
  logic [1:0] fw;

  // Out-of-range contexts see zero flags, fail the condition and touch no state.
  assign ctx_ok    = (int'(ctx) < NCTX);
  assign cur_flags = ctx_ok ? flags_q[ctx] : '0;

  cond_eval u_eval (
    .cond      (cond),
    .flags     (cur_flags),
    .nv_always (NV_ALWAYS != 0),
    .cond_ex   (eval_ex)
  );

  assign cond_ex = ctx_ok & eval_ex;
  assign accept  = in_valid & ~stall & ~flush;
  assign upd     = accept & ctx_ok;
  assign fw      = flag_w & {2{cond_ex | (GATE_FLAGS == 0)}};

  // Restore overrides ALU writes; save always captures the pre-edge value,
  // so save+restore together swaps the two banks.
  always_comb begin
    new_flags = cur_flags;
    if (fw[1])        new_flags[FLAG_N:FLAG_Z] = alu_flag[FLAG_N:FLAG_Z];
    if (fw[0])        new_flags[FLAG_C:FLAG_V] = alu_flag[FLAG_C:FLAG_V];
    if (flag_restore) new_flags = saved_q[ctx];
  end

  always_comb begin
    flags_d = flags_q;
    saved_d = saved_q;
    if (upd) begin
      flags_d[ctx] = new_flags;
      if (flag_save) saved_d[ctx] = cur_flags;
    end
  end

  // Flush beats stall; stall holds; otherwise capture or bubble.
  always_comb begin
    out_d = '0;
    if (flush) begin
      out_d = '0;
    end else if (stall) begin
      out_d = out_q;
    end else if (in_valid) begin
      out_d.valid       = 1'b1;
      out_d.cond_ex     = cond_ex;
      out_d.pc_src      = pcs & cond_ex;
      out_d.reg_write   = reg_w & cond_ex & ~no_write;
      out_d.mem_write   = mem_w & cond_ex;
      out_d.branch_take = branch & cond_ex;
    end
  end

  // Counter holds on stall/flush edges; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall && !flush) begin
      if (cnt_clr)
        cnt_d = '0;
      else if (upd && !cond_ex && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCTX; i++) begin
        flags_q[i] <= '0;
        saved_q[i] <= '0;
      end
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = out_q.valid;
  assign pc_src      = out_q.pc_src;
  assign reg_write   = out_q.reg_write;
  assign mem_write   = out_q.mem_write;
  assign branch_take = out_q.branch_take;
  assign cond_ex_q   = out_q.cond_ex;
  assign flags_o     = cur_flags;
  assign annul_cnt   = cnt_q;

endmodule
